// File: rtl/xif_mem_splitter_if.sv
// Bundle of the core-side and memory-side signals of the misaligned-access
// splitter. The slave modport is the splitter's own view; master is the
// environment driving the core requests and serving memory.
interface xif_mem_splitter_if #(
    parameter int ADDR_WIDTH = 32
);
    // core side
    logic                  core_req_i;
    logic                  core_ready_o;
    logic [ADDR_WIDTH-1:0] core_addr_i;
    logic                  core_we_i;
    logic [1:0]            core_size_i;
    logic [31:0]           core_wdata_i;
    logic                  core_rvalid_o;
    logic [31:0]           core_rdata_o;
    logic                  core_err_o;
    // memory side
    logic                  data_req_o;
    logic                  data_gnt_i;
    logic [ADDR_WIDTH-1:0] data_addr_o;
    logic                  data_we_o;
    logic [3:0]            data_be_o;
    logic [31:0]           data_wdata_o;
    logic                  data_rvalid_i;
    logic [31:0]           data_rdata_i;
    logic                  data_err_i;
    logic                  data_misaligned_first_o;
    logic                  data_misaligned_second_o;

    modport slave (
        input  core_req_i, core_addr_i, core_we_i, core_size_i, core_wdata_i,
        output core_ready_o, core_rvalid_o, core_rdata_o, core_err_o,
        output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        output data_misaligned_first_o, data_misaligned_second_o,
        input  data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
    );

    modport master (
        output core_req_i, core_addr_i, core_we_i, core_size_i, core_wdata_i,
        input  core_ready_o, core_rvalid_o, core_rdata_o, core_err_o,
        input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        input  data_misaligned_first_o, data_misaligned_second_o,
        output data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
    );
endinterface

// File: rtl/xif_mem_splitter.sv
// Splits misaligned core loads/stores into one or two word-aligned memory
// accesses, merges split load data and reports a single completion.
// Only one memory access is ever outstanding.
module xif_mem_splitter #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    xif_mem_splitter_if.slave   bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ_A = 3'd1;
    localparam logic [2:0] RSP_A = 3'd2;
    localparam logic [2:0] REQ_B = 3'd3;
    localparam logic [2:0] RSP_B = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic [1:0]            r_size;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rdata;
    logic                  r_err;

    logic [1:0]            w_off;
    logic                  w_split;
    logic [3:0]            w_mask;
    logic [7:0]            w_be_wide;
    logic [4:0]            w_sha;     // 8*off: shift for the first word
    logic [5:0]            w_shb;     // 8*(4-off): shift for the second word
    logic [ADDR_WIDTH-1:0] w_addr_a;
    logic [ADDR_WIDTH-1:0] w_addr_b;

    // Decode the latched command into lane offset, split flag and shifts
    always_comb begin
        w_off     = r_addr[1:0];
        w_mask    = (r_size == 2'd0) ? 4'b0001 :
                    (r_size == 2'd1) ? 4'b0011 : 4'b1111;
        w_split   = ((r_size == 2'd1) && (w_off == 2'd3)) ||
                    (r_size[1] && (w_off != 2'd0));
        w_be_wide = {4'b0000, w_mask} << w_off;
        w_sha     = {w_off, 3'b000};
        w_shb     = 6'd32 - {1'b0, w_off, 3'b000};
        w_addr_a  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
        // natural overflow of the add wraps the second word to address 0
        w_addr_b  = w_addr_a + ADDR_WIDTH'(4);
    end

    // Sequencer: accept, issue one or two aligned accesses, complete
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_size  <= 2'd0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.core_req_i) begin
                        r_addr  <= bus.core_addr_i;
                        r_we    <= bus.core_we_i;
                        r_size  <= bus.core_size_i;
                        r_wdata <= bus.core_wdata_i;
                        r_rdata <= '0;
                        r_err   <= 1'b0;
                        r_state <= REQ_A;
                    end
                end
                REQ_A: if (bus.data_gnt_i) r_state <= RSP_A;
                RSP_A: begin
                    if (bus.data_rvalid_i) begin
                        // first word already shifted down so an unsplit
                        // access needs no further alignment
                        r_rdata <= bus.data_rdata_i >> w_sha;
                        r_err   <= bus.data_err_i;
                        r_state <= w_split ? REQ_B : DONE;
                    end
                end
                REQ_B: if (bus.data_gnt_i) r_state <= RSP_B;
                RSP_B: begin
                    if (bus.data_rvalid_i) begin
                        r_rdata <= r_rdata | (bus.data_rdata_i << w_shb);
                        r_err   <= r_err | bus.data_err_i;
                        r_state <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Drive memory request and core completion from state and latched data
    always_comb begin
        bus.core_ready_o             = (r_state == IDLE);
        bus.core_rvalid_o            = 1'b0;
        bus.core_rdata_o             = '0;
        bus.core_err_o               = 1'b0;
        bus.data_req_o               = 1'b0;
        bus.data_addr_o              = '0;
        bus.data_we_o                = 1'b0;
        bus.data_be_o                = 4'b0000;
        bus.data_wdata_o             = '0;
        bus.data_misaligned_first_o  = 1'b0;
        bus.data_misaligned_second_o = 1'b0;
        case (r_state)
            REQ_A: begin
                bus.data_req_o              = 1'b1;
                bus.data_addr_o             = w_addr_a;
                bus.data_we_o               = r_we;
                bus.data_be_o               = w_be_wide[3:0];
                bus.data_wdata_o            = r_wdata << w_sha;
                bus.data_misaligned_first_o = w_split;
            end
            REQ_B: begin
                bus.data_req_o               = 1'b1;
                bus.data_addr_o              = w_addr_b;
                bus.data_we_o                = r_we;
                bus.data_be_o                = ((r_size == 2'd1) && (w_off == 2'd3)) ?
                                               4'b0001 : ((4'b0001 << w_off) - 4'b0001);
                bus.data_wdata_o             = r_wdata >> w_shb;
                bus.data_misaligned_second_o = 1'b1;
            end
            DONE: begin
                bus.core_rvalid_o = 1'b1;
                bus.core_err_o    = r_err;
                if (!r_we) begin
                    case (r_size)
                        2'd0:    bus.core_rdata_o = {24'b0, r_rdata[7:0]};
                        2'd1:    bus.core_rdata_o = {16'b0, r_rdata[15:0]};
                        default: bus.core_rdata_o = r_rdata;
                    endcase
                end
            end
            default: ;
        endcase
    end
endmodule
